// File: rtl/i2c_sample_proc.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_sample_proc
//  Description : Post-processing for sensor bytes read by the I2C master.
//                Keeps a moving average over a 2^AVG_LOG2 window and drives
//                a hysteresis alarm, an 8-LED thermometer bar, a stale-data
//                watchdog and a sticky overrun flag.
//                Optional feature macro: PEAK_HOLD_EN (peak-hold with decay).
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_sample_proc #(
    parameter int          AVG_LOG2     = 2,
    parameter logic [7:0]  THRESH_HI    = 8'd160,
    parameter logic [7:0]  THRESH_LO    = 8'd96,
    parameter logic [27:0] STALE_CYCLES = 28'd50000000
`ifdef PEAK_HOLD_EN
    ,
    parameter logic [23:0] PEAK_DECAY   = 24'd5000000
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic [7:0] avg,
    output logic       avg_valid,
    output logic       alarm,
    output logic       stale,
    output logic       overrun,
    output logic [7:0] sample_cnt,
    output logic [7:0] LED,
    output logic [7:0] peak
);

    localparam int                  c_DEPTH  = 1 << AVG_LOG2;
    localparam int                  c_SUM_W  = 8 + AVG_LOG2;
    localparam logic [AVG_LOG2-1:0] c_WR_ONE = 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SUM  = 2'd1,
        S_AVG  = 2'd2,
        S_CMP  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [7:0]           r_byte;
    logic [7:0]           r_buf [c_DEPTH];
    logic [c_SUM_W-1:0]   r_sum;
    logic [AVG_LOG2-1:0]  r_wr;
    logic [7:0]           r_avg_next;
    logic [27:0]          r_stale_cnt;
    logic                 w_accept;
    logic [7:0]           w_led;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state logic; the block only takes a byte while idle
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_next = S_SUM;
            end
            S_SUM:   w_state_next = S_AVG;
            S_AVG:   w_state_next = S_CMP;
            S_CMP:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_accept = in_valid & in_ready;

    // Window datapath: replace oldest slot, keep running sum, then divide
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_byte     <= 8'd0;
            r_sum      <= '0;
            r_wr       <= '0;
            r_avg_next <= 8'd0;
            for (int i = 0; i < c_DEPTH; i++) r_buf[i] <= 8'd0;
        end else begin
            if (w_accept) r_byte <= in_data;
            if (r_state == S_SUM) begin
                r_sum       <= r_sum - {{AVG_LOG2{1'b0}}, r_buf[r_wr]}
                                     + {{AVG_LOG2{1'b0}}, r_byte};
                r_buf[r_wr] <= r_byte;
                r_wr        <= r_wr + c_WR_ONE;
            end
            if (r_state == S_AVG) r_avg_next <= r_sum[AVG_LOG2 +: 8];
        end
    end

    // Thermometer bar: LED0 lights for any non-zero average, LEDi from 32*i
    for (genvar gi = 0; gi < 8; gi++) begin : g_led
        assign w_led[gi] = (r_avg_next >= 8'((gi == 0) ? 1 : gi * 32));
    end

    // Result registers, updated once per sample as the FSM leaves CMP
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            avg       <= 8'd0;
            LED       <= 8'd0;
            alarm     <= 1'b0;
            avg_valid <= 1'b0;
        end else begin
            avg_valid <= (r_state == S_CMP);
            if (r_state == S_CMP) begin
                avg <= r_avg_next;
                LED <= w_led;
                if (r_avg_next >= THRESH_HI)      alarm <= 1'b1;
                else if (r_avg_next <= THRESH_LO) alarm <= 1'b0;
            end
        end
    end

    // Sample counter, sticky overrun and stale watchdog
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_cnt  <= 8'd0;
            overrun     <= 1'b0;
            r_stale_cnt <= 28'd0;
        end else begin
            if (w_accept) begin
                if (sample_cnt != 8'hFF) sample_cnt <= sample_cnt + 8'd1;
                r_stale_cnt <= 28'd0;
            end else if (r_stale_cnt != STALE_CYCLES) begin
                r_stale_cnt <= r_stale_cnt + 28'd1;
            end
            if (in_valid && !in_ready) overrun <= 1'b1;
        end
    end

    assign stale = (r_stale_cnt == STALE_CYCLES);

`ifdef PEAK_HOLD_EN
    logic [23:0] r_decay_cnt;

    // Peak-hold: capture new maxima, otherwise bleed off one LSB per period
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            peak        <= 8'd0;
            r_decay_cnt <= 24'd0;
        end else if (r_state == S_CMP) begin
            r_decay_cnt <= 24'd0;
            if (r_avg_next > peak) peak <= r_avg_next;
        end else if (r_decay_cnt == PEAK_DECAY - 24'd1) begin
            r_decay_cnt <= 24'd0;
            if (peak != 8'd0) peak <= peak - 8'd1;
        end else begin
            r_decay_cnt <= r_decay_cnt + 24'd1;
        end
    end
`else
    assign peak = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_i2c_sample_proc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_sample_proc
//  Description : Self-checking bench for i2c_sample_proc. A reference model
//                predicts each average/alarm/LED result and its arrival
//                cycle; a monitor pops and compares on every avg_valid.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_i2c_sample_proc;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [7:0] avg;
    logic       avg_valid;
    logic       alarm;
    logic       stale;
    logic       overrun;
    logic [7:0] sample_cnt;
    logic [7:0] LED;
    logic [7:0] peak;

    i2c_sample_proc #(
        .STALE_CYCLES (28'd100)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .avg        (avg),
        .avg_valid  (avg_valid),
        .alarm      (alarm),
        .stale      (stale),
        .overrun    (overrun),
        .sample_cnt (sample_cnt),
        .LED        (LED),
        .peak       (peak)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] avg;
        logic       alarm;
        logic [7:0] led;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   errors  = 0;

    // Reference model state
    int   m_win[4];
    int   m_sum;
    int   m_wr;
    logic m_alarm;
    int   last_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] led_of(input logic [7:0] a);
        logic [7:0] l;
        l = 8'h00;
        for (int i = 0; i < 8; i++) l[i] = (a != 8'd0) && (int'(a[7:5]) >= i);
        return l;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_win[i] = 0;
        m_sum   = 0;
        m_wr    = 0;
        m_alarm = 1'b0;
        sb.delete();
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after the accept
    task automatic send(input logic [7:0] b);
        exp_t       e;
        logic [7:0] a;
        chk("in_ready_before_send", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = b;
        m_sum    = m_sum - m_win[m_wr] + int'(b);
        m_win[m_wr] = int'(b);
        m_wr     = (m_wr + 1) % 4;
        a        = 8'(m_sum / 4);
        if (a >= 8'd160)     m_alarm = 1'b1;
        else if (a <= 8'd96) m_alarm = 1'b0;
        e.avg    = a;
        e.alarm  = m_alarm;
        e.led    = led_of(a);
        e.cyc    = cyc + 4;
        sb.push_back(e);
        last_acc = cyc + 1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'd0;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (avg_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_avg_valid", {31'd0, avg_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("avg",          {24'd0, avg},   {24'd0, e.avg});
                chk("alarm",        {31'd0, alarm}, {31'd0, e.alarm});
                chk("LED",          {24'd0, LED},   {24'd0, e.led});
                chk("valid_cycle",  cyc,            e.cyc);
            end
        end
    end

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'd0;
        last_acc = 0;
        model_clear();
        idle(3);

        // Reset state
        chk("rst_avg",        {24'd0, avg},        32'd0);
        chk("rst_LED",        {24'd0, LED},        32'd0);
        chk("rst_alarm",      {31'd0, alarm},      32'd0);
        chk("rst_stale",      {31'd0, stale},      32'd0);
        chk("rst_overrun",    {31'd0, overrun},    32'd0);
        chk("rst_sample_cnt", {24'd0, sample_cnt}, 32'd0);
        chk("rst_in_ready",   {31'd0, in_ready},   32'd1);
        chk("rst_avg_valid",  {31'd0, avg_valid},  32'd0);
        chk("rst_peak",       {24'd0, peak},       32'd0);
        reset = 1'b0;
        idle(1);

        // Ramp up with four 200s
        repeat (4) begin
            send(8'd200);
            idle(5);
        end
        chk("ramp_avg",   {24'd0, avg},        32'd200);
        chk("ramp_alarm", {31'd0, alarm},      32'd1);
        chk("ramp_LED",   {24'd0, LED},        32'h7F);
        chk("ramp_cnt",   {24'd0, sample_cnt}, 32'd4);

        // Fall through the hysteresis band with four 80s
        repeat (4) begin
            send(8'd80);
            idle(5);
        end
        chk("fall_avg",   {24'd0, avg},        32'd80);
        chk("fall_alarm", {31'd0, alarm},      32'd0);
        chk("fall_LED",   {24'd0, LED},        32'h07);
        chk("fall_cnt",   {24'd0, sample_cnt}, 32'd8);

        // Overrun: second strobe one clock after an accept is dropped
        send(8'd40);
        in_valid = 1'b1;
        in_data  = 8'd255;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'd0;
        @(negedge clk);
        chk("overrun_set", {31'd0, overrun},    32'd1);
        chk("overrun_cnt", {24'd0, sample_cnt}, 32'd9);
        idle(5);
        chk("overrun_avg",    {24'd0, avg},     32'd70);
        chk("overrun_sticky", {31'd0, overrun}, 32'd1);

        // Stale watchdog rises 100 cycles after the last accept
        chk("stale_low_early", {31'd0, stale}, 32'd0);
        for (int i = 0; i < 300 && stale !== 1'b1; i++) @(negedge clk);
        chk("stale_rise_cycle", cyc, last_acc + 100);
        idle(3);
        chk("stale_held", {31'd0, stale}, 32'd1);
        send(8'd120);
        chk("stale_cleared", {31'd0, stale}, 32'd0);
        idle(5);
        chk("stale_avg", {24'd0, avg}, 32'd80);

        // Reset while the FSM sits in AVG aborts the sample
        send(8'd50);
        @(negedge clk);
        chk("busy_in_ready", {31'd0, in_ready}, 32'd0);
        reset = 1'b1;
        model_clear();
        #1;
        chk("abort_avg",     {24'd0, avg},        32'd0);
        chk("abort_LED",     {24'd0, LED},        32'd0);
        chk("abort_overrun", {31'd0, overrun},    32'd0);
        chk("abort_cnt",     {24'd0, sample_cnt}, 32'd0);
        chk("abort_ready",   {31'd0, in_ready},   32'd1);
        idle(3);
        reset = 1'b0;
        idle(8);

        // LED boundaries: small non-zero average and full scale
        send(8'd100);
        idle(5);
        chk("small_LED", {24'd0, LED}, 32'h01);
        repeat (4) begin
            send(8'd255);
            idle(5);
        end
        chk("full_avg",   {24'd0, avg},   32'd255);
        chk("full_LED",   {24'd0, LED},   32'hFF);
        chk("full_alarm", {31'd0, alarm}, 32'd1);
        chk("peak_tied",  {24'd0, peak},  32'd0);

        idle(6);
        chk("sb_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
